// File: rtl/seq_multiplier_pkg.sv
//------------------------------------------------------------------------------
// seq_multiplier_pkg : state encoding and sizing helpers for iterative arithmetic
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // One extra bit so the iteration counter never wraps at WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_multiplier_cla_adder.sv
//------------------------------------------------------------------------------
// cla_adder : combinational adder, BLK-bit lookahead groups with rippled group carries
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGRP = WIDTH / BLK;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [BLK-1:0] gp;
    logic [BLK-1:0] gg;
    logic [BLK:0]   gcarry;
    logic           gcin;
    logic           gcout;
    logic           c_acc;
    logic           p_acc;

    if (gi == 0) begin : g_first
      assign gcin = cin;
    end else begin : g_rest
      assign gcin = g_grp[gi-1].gcout;
    end

    assign gp = a[gi*BLK +: BLK] ^ b[gi*BLK +: BLK];
    assign gg = a[gi*BLK +: BLK] & b[gi*BLK +: BLK];

    // Each bit carry is the flat OR-of-products over lower generates and the group carry-in.
    always_comb begin
      c_acc     = 1'b0;
      p_acc     = 1'b1;
      gcarry    = '0;
      gcarry[0] = gcin;
      for (int i = 1; i <= BLK; i++) begin
        c_acc = 1'b0;
        p_acc = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          c_acc = c_acc | (p_acc & gg[j]);
          p_acc = p_acc & gp[j];
        end
        gcarry[i] = c_acc | (p_acc & gcin);
      end
    end

    assign sum[gi*BLK +: BLK] = gp ^ gcarry[BLK-1:0];
    assign gcout              = gcarry[BLK];
  end

  assign cout = g_grp[NGRP-1].gcout;

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
//------------------------------------------------------------------------------
// seq_multiplier : shift-add WIDTH x WIDTH -> 2*WIDTH multiplier, signed/unsigned, valid/ready
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CLA_BLK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   add_b, add_sum;
  logic               add_c;
  logic [2*WIDTH-1:0] neg_sum;
  logic               neg_cout_unused;
  logic               accept;

  assign a_mag = (signed_mode && multiplicand[WIDTH-1]) ? (~multiplicand + WIDTH'(1)) : multiplicand;
  assign b_mag = (signed_mode && multiplier[WIDTH-1])   ? (~multiplier + WIDTH'(1))   : multiplier;

  assign add_b = lo_q[0] ? mag_a_q : '0;

  cla_adder #(.WIDTH(WIDTH), .BLK(CLA_BLK)) u_step_add (
    .a    (hi_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_c)
  );

  // Two's-complement negate of the full product: ~x + 1.
  cla_adder #(.WIDTH(2*WIDTH), .BLK(CLA_BLK)) u_neg_add (
    .a    (~{hi_q, lo_q}),
    .b    ({(2*WIDTH){1'b0}}),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (neg_cout_unused)
  );

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign product   = product_q;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mag_a_d   = mag_a_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_CALC: begin
        // Carry becomes the new HI MSB; the sum LSB shifts into LO as the multiplier retires.
        hi_d  = {add_c, add_sum[WIDTH-1:1]};
        lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        product_d = neg_q ? neg_sum : {hi_q, lo_q};
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (accept) begin
      mag_a_d = a_mag;
      neg_d   = signed_mode && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      hi_d    = '0;
      lo_d    = b_mag;
      cnt_d   = '0;
      state_d = S_CALC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mag_a_q   <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mag_a_q   <= mag_a_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
//------------------------------------------------------------------------------
// tb_seq_multiplier : scoreboard bench for seq_multiplier (WIDTH=32)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] product;
  logic           busy;

  int             n_checks = 0;
  int             n_fail   = 0;
  int             cyc      = 0;

  logic [2*W-1:0] exp_q[$];
  int             acc_q[$];
  bit             first_seen = 0;
  bit             have_prev  = 0;
  logic [2*W-1:0] prev_prod  = '0;

  seq_multiplier #(.WIDTH(W), .CLA_BLK(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Monitor: push on accept, pop on delivery, plus latency and hold checks.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      first_seen = 0;
      have_prev  = 0;
    end else begin
      if (out_valid) begin
        if (have_prev) check("hold", product, prev_prod);
        if (!first_seen) begin
          if (acc_q.size() == 0) check("spurious_valid", 1, 0);
          // Sampled one cycle before the accepting edge, hence WIDTH+2.
          else check("latency", 2*W'(cyc - acc_q[0]), 2*W'(W + 2));
          first_seen = 1;
        end
        prev_prod = product;
        have_prev = 1;
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_product", 1, 0);
          end else begin
            check("product", product, exp_q.pop_front());
            void'(acc_q.pop_front());
          end
          first_seen = 0;
          have_prev  = 0;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(multiplicand, multiplier, signed_mode));
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit rnd);
    bit got;
    int n;
    n = 0;
    multiplicand = a;
    multiplier   = b;
    signed_mode  = s;
    in_valid     = 1'b1;
    forever begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      if (got) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    in_valid     = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    signed_mode  = $urandom_range(0, 1);
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    forever begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (!busy && !out_valid && exp_q.size() == 0) break;
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        check("drain_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return {1'b1, {(W-1){1'b0}}};
      4:       return {1'b0, {(W-1){1'b1}}};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner products
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    drain(0);
    send(32'hFFFF_FFFD, 32'd7, 1'b1, 0);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    drain(0);
    check("const_unsigned_max", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);

    // Back-pressure then back-to-back accept in the same cycle as delivery
    out_ready = 1'b0;
    send(32'd7, 32'd11, 1'b0, 0);
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_product", product, 64'd77);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'd5, 32'd6, 1'b0, 0);
    drain(0);

    // Operands offered while busy must be ignored
    send(32'd100, 32'd200, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    in_valid     = 1'b1;
    @(negedge clk);
    check("busy_flag", busy, 1);
    check("busy_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(0);

    // Asynchronous reset in the middle of CALC
    send(32'd1234, 32'd5678, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_product", product, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'd2, 32'd3, 1'b0, 0);
    drain(0);
    check("after_rst_product", product, 64'd6);

    // Randomised traffic with random back-pressure, both modes
    for (int k = 0; k < 400; k++) begin
      send(pick_operand(), pick_operand(), $urandom_range(0, 1), 1);
    end
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
